// File: rtl/text_console.sv
// text_console: byte-stream console front end with a scrolling text-buffer RAM.
// A byte stream arrives on a valid/ready handshake and is decoded into cursor moves
// or glyph writes. The video controller reads the same RAM through a second port.
// Both ports apply the hardware-scroll row offset (top_row) to the logical address.
module text_console #(
   parameter int unsigned TextCols = 64,
   parameter int unsigned TextRows = 32,
   parameter logic [7:0]  Blank    = 8'h20,
   localparam int unsigned N       = TextCols * TextRows,
   localparam int unsigned A       = $clog2(N),
   localparam int unsigned CW      = $clog2(TextCols),
   localparam int unsigned RW      = $clog2(TextRows)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [A-1:0]  vid_addr,
   output logic [7:0]    vid_data,
   output logic [CW-1:0] cur_col,
   output logic [RW-1:0] cur_row,
   output logic [RW-1:0] top_row
);

   localparam logic [7:0] ChBs = 8'h08;
   localparam logic [7:0] ChLf = 8'h0A;
   localparam logic [7:0] ChFf = 8'h0C;
   localparam logic [7:0] ChCr = 8'h0D;

   typedef enum logic [1:0] {
      sClearAll,
      sIdle,
      sClearRow
   } state_t;

   state_t        state_q;
   logic [A-1:0]  cnt_q;       // physical address of the next blank write during a clear
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [RW-1:0] top_q;
   logic          ready_q;
   logic [7:0]    vid_q;

   logic [7:0]    mem [N];

   logic          xfer;
   logic          is_print;
   logic          last_col;
   logic          last_row;
   logic          adv;
   logic [RW-1:0] cur_prow;
   logic [A-1:0]  cur_addr;
   logic [RW-1:0] rd_prow;
   logic [A-1:0]  rd_addr;
   logic          we;
   logic [A-1:0]  waddr;
   logic [7:0]    wdata;

   assign in_ready = ready_q;
   assign vid_data = vid_q;
   assign cur_col  = col_q;
   assign cur_row  = row_q;
   assign top_row  = top_q;

   // Decode the accepted byte and translate both ports' logical rows to physical rows.
   always_comb begin
      xfer     = ready_q && in_valid;
      is_print = !(in_data == ChLf || in_data == ChCr || in_data == ChBs || in_data == ChFf);
      last_col = (col_q == CW'(TextCols - 1));
      last_row = (row_q == RW'(TextRows - 1));
      // A line advance comes from LF or from a printable byte written in the last column.
      adv      = xfer && ((in_data == ChLf) || (is_print && last_col));
      cur_prow = row_q + top_q;
      cur_addr = {cur_prow, col_q};
      rd_prow  = vid_addr[A-1:CW] + top_q;
      rd_addr  = {rd_prow, vid_addr[CW-1:0]};
   end

   // Select the console write: blank fill while clearing, otherwise the cursor glyph.
   always_comb begin
      we    = 1'b0;
      waddr = cnt_q;
      wdata = Blank;
      if (state_q != sIdle) begin
         we = 1'b1;
      end else if (xfer && is_print) begin
         we    = 1'b1;
         waddr = cur_addr;
         wdata = in_data;
      end
   end

   // Console FSM: clear sequencing, cursor tracking, scrolling and registered ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= sClearAll;
         cnt_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         top_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            sClearAll: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == A'(N - 1)) begin
                  state_q <= sIdle;
                  ready_q <= 1'b1;
                  col_q   <= '0;
                  row_q   <= '0;
                  top_q   <= '0;
               end
            end
            sClearRow: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q[CW-1:0] == '1) begin
                  state_q <= sIdle;
                  ready_q <= 1'b1;
               end
            end
            sIdle: begin
               if (xfer) begin
                  if (in_data == ChLf || in_data == ChCr) begin
                     col_q <= '0;
                  end else if (in_data == ChBs) begin
                     if (col_q != '0) col_q <= col_q - 1'b1;
                  end else if (in_data == ChFf) begin
                     state_q <= sClearAll;
                     cnt_q   <= '0;
                     ready_q <= 1'b0;
                  end else begin
                     col_q <= last_col ? '0 : col_q + 1'b1;
                  end
                  if (adv) begin
                     if (!last_row) begin
                        row_q <= row_q + 1'b1;
                     end else begin
                        // The old top physical row becomes the new bottom screen row.
                        top_q   <= top_q + 1'b1;
                        cnt_q   <= {top_q, {CW{1'b0}}};
                        state_q <= sClearRow;
                        ready_q <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q <= sClearAll;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Console write port; the RAM itself is not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Video read port; a same-cycle write to the read cell returns the old data.
   always_ff @(posedge clk) begin
      if (reset) vid_q <= '0;
      else       vid_q <= mem[rd_addr];
   end

endmodule

// File: doc/text_console.md
# text_console

Character-stream front end and text-buffer RAM for the 64x32 VGA text display. It accepts a byte stream over a valid/ready handshake and interprets a small set of control codes. It maintains a cursor and hardware scrolling, and stores glyph codes in an internal dual-port RAM. The video controller reads the RAM directly via `vid_addr`/`vid_data`, which drive that controller's text address and data ports.

## Interface
- `TextCols`, 64, characters per row; power of two.
- `TextRows`, 32, rows per screen; power of two.
- `Blank`, 8'h20, fill code written by clears.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_data`  in  8  character/control byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept a byte this cycle.
- `vid_addr`  in  A = clog2(TextCols*TextRows)  logical cell address, `row*TextCols + col`.
- `vid_data`  out  8  glyph code at `vid_addr`, registered.
- `cur_col`  out  clog2(TextCols)  cursor column.
- `cur_row`  out  clog2(TextRows)  cursor row, logical (0 = top of screen).
- `top_row`  out  clog2(TextRows)  physical RAM row currently shown as screen row 0.

## Operation
- **Storage:** RAM of `TextCols*TextRows` bytes, with one write port (console) and one read port (video).
- **Address translation:** physical address = `((logical_row + top_row) mod TextRows)*TextCols + col`. Both ports use this translation; mod is natural wrap of the row width.
- **States:** `sClearAll`, `sIdle`, `sClearRow`.
- **sClearAll:**
  - Writes `Blank` to physical addresses 0..N-1, one per cycle, N = `TextCols*TextRows`.
  - Then goes to `sIdle` with cursor (0,0) and `top_row` 0.
- **sIdle:**
  - `in_ready`=1.
  - A transfer occurs on a rising edge with `in_valid && in_ready`.
- **sClearRow:**
  - Writes `Blank` to the 64 cells of the physical row given by the new bottom screen row, one per cycle.
  - Then returns to `sIdle`.
- **Byte decode on transfer:**
  - **0x0A (LF):** col←0, line advance.
  - **0x0D (CR):** col←0.
  - **0x08 (BS):** col←col-1 if col>0, else unchanged; no erase.
  - **0x0C (FF):** enter `sClearAll`.
  - **Any other byte:** write to the cursor cell. If col<TextCols-1, col+1. Otherwise col←0 and line advance.
- **Line advance:**
  - If `cur_row` < TextRows-1: `cur_row`+1.
  - Else: `cur_row` unchanged, `top_row`←`top_row`+1 (wraps at TextRows-1→0), enter `sClearRow` for physical row = old `top_row`.
- **Reads:** the read port is independent of console state and always serviced, including during clears.
- **Read/write collision:** a write to the same physical cell as a read in the same cycle returns the old data.

## Timing
- **Reset:**
  - `reset` dominates all other inputs, including mid-clear and mid-transfer.
  - The following edge forces `sClearAll` with the clear counter at 0, `cur_col`=`cur_row`=`top_row`=0, `in_ready`=0, `vid_data`=0.
  - RAM contents are undefined until the clear completes.
- **Clear durations:**
  - `sClearAll` lasts exactly N cycles (2048 at defaults); `in_ready` rises in cycle N+1 after reset release.
  - `sClearRow` lasts exactly `TextCols` cycles (64); `in_ready` is low throughout.
- **`in_ready` timing:**
  - It is a registered function of state. It drops the cycle after a transfer that triggers a clear and stays high after any other transfer.
  - Back-to-back printable bytes are accepted at 1/cycle.
- **Write timing:** the character write lands on the transfer edge. Cursor outputs update on that same edge.
- **`top_row` timing:**
  - `top_row` updates on the transfer edge that causes the scroll.
  - Video reads of the new bottom row show stale data until `sClearRow` finishes; this is an accepted artefact.
- **Read latency:** `vid_data` reflects `vid_addr` sampled on the previous edge. Translation uses the `top_row` value at the sampling edge.
- **Control bytes:** all control bytes are consumed in one cycle. FF takes N+1 cycles until the next acceptance.

## Test plan
- **Reset clear:** reset 1 cycle. Expect `in_ready`=0 for 2048 cycles and then 1. Expect every `vid_addr` 0..2047 to read 0x20, and cursor (0,0).
- **Write and read-back:** send "AB", CR, "C". Expect `vid_addr` 0 → 0x43 and `vid_addr` 1 → 0x42, each one cycle after the address; cursor (1,0).
- **Column wrap and backspace:** send 64× 0x41. Expect cursor (0,1). Then send BS, which leaves the cursor at (0,1); BS at col 0 is a no-op.
- **Scroll:** send 32× LF from (0,0). Expect `top_row`=1, `cur_row`=31, `in_ready` low exactly 64 cycles. Afterwards, logical row 31 reads 0x20 and logical row 0 shows old physical row 1.
- **Form feed and reset mid-clear:**
  - Send FF after content. Expect 2048 blank cycles, cursor and `top_row` 0, and all cells 0x20.
  - Assert reset at cycle 1000 of that clear. Expect the clear to restart from 0 and `in_ready` to return 2048 cycles later.
- **Collision and backpressure:**
  - Hold `in_valid` high with a new byte each cycle through a scroll. Expect no byte lost or duplicated.
  - Read the cell being written in the same cycle. Expect the old value.
